// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// HAZARD_PERF_CNT_EN enables the stall/flush performance counters.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_LDSTALL = 2'd2,
    ST_FLUSH   = 2'd3
  } hz_state_e;

  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  localparam logic [1:0]  PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0]  PC_SEL_ALU   = 2'd1;
  localparam logic [1:0]  PC_SEL_RST   = 2'd3;

  localparam int unsigned CNT_W        = 32;
  localparam int unsigned BOOT_CNT_W   = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between stage-2 load and stage-1 sources.
// Purely combinational.
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       load_s2,
  input  logic [4:0] rd_s2,
  input  logic [4:0] rs1_s1,
  input  logic [4:0] rs2_s1,
  input  logic       rs1_used_s1,
  input  logic       rs2_used_s1,
  output logic       hit
);

  logic rd_nz;
  logic rs1_m;
  logic rs2_m;

  assign rd_nz = |rd_s2;
  assign rs1_m = rs1_used_s1 && (rs1_s1 == rd_s2);
  assign rs2_m = rs2_used_s1 && (rs2_s1 == rd_s2);
  assign hit   = load_s2 && rd_nz && (rs1_m || rs2_m);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/bubble controller with boot sequencing.
// Optional counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned IMEM_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_s3,
  input  logic        load_s2,
  input  logic [4:0]  rd_s2,
  input  logic [4:0]  rs1_s1,
  input  logic [4:0]  rs2_s1,
  input  logic        rs1_used_s1,
  input  logic        rs2_used_s1,
  input  logic        mem_busy,
  output logic        pc_rst,
  output logic        stall_pc,
  output logic        stall_s1,
  output logic        stall_s2,
  output logic        stall_s3,
  output logic        bubble_s2,
  output logic        flush_s1,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST =
    BOOT_CNT_W'(BOOT_CYCLES - 1);

  hz_state_e             state_q;
  hz_state_e             state_d;
  logic [BOOT_CNT_W-1:0] boot_q;
  logic [BOOT_CNT_W-1:0] boot_d;
  logic                  pend_q;
  logic                  pend_d;
  logic                  hit;
  logic                  redir_eff;

  pipeline_hazard_ctrl_hazard_detect u_hd (
    .load_s2     (load_s2),
    .rd_s2       (rd_s2),
    .rs1_s1      (rs1_s1),
    .rs2_s1      (rs2_s1),
    .rs1_used_s1 (rs1_used_s1),
    .rs2_used_s1 (rs2_used_s1),
    .hit         (hit)
  );

  assign redir_eff = (redirect_s3 || pend_q) && !mem_busy
                   && (state_q != ST_BOOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      boot_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    boot_d    = boot_q;
    pend_d    = pend_q;
    pc_rst    = 1'b0;
    stall_pc  = 1'b0;
    stall_s1  = 1'b0;
    stall_s2  = 1'b0;
    stall_s3  = 1'b0;
    bubble_s2 = 1'b0;
    flush_s1  = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        pc_rst    = 1'b1;
        flush_s1  = 1'b1;
        bubble_s2 = 1'b1;
        boot_d    = boot_q + 1'b1;
        if (boot_q == BOOT_LAST) begin
          state_d = ST_RUN;
          boot_d  = '0;
        end
      end
      default: begin
        if (mem_busy) begin
          // Whole pipe frozen; remember a redirect for when it thaws.
          stall_pc = 1'b1;
          stall_s1 = 1'b1;
          stall_s2 = 1'b1;
          stall_s3 = 1'b1;
          pend_d   = pend_q || redirect_s3;
        end else if (redir_eff) begin
          flush_s1  = 1'b1;
          bubble_s2 = 1'b1;
          pend_d    = 1'b0;
          state_d   = (IMEM_LAT == 1) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH) begin
          flush_s1 = 1'b1;
          state_d  = ST_RUN;
        end else if (hit) begin
          stall_pc  = 1'b1;
          stall_s1  = 1'b1;
          bubble_s2 = 1'b1;
          state_d   = ST_LDSTALL;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_pc)
        stall_q <= stall_q + 1'b1;
      if (redir_eff)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors,
// expected outputs queued by stimulus, popped by a monitor.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
    int          id;
  } exp_t;

  localparam logic [6:0] C_BOOT  = 7'b1000011;
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_HAZ   = 7'b0110010;
  localparam logic [6:0] C_BUSY  = 7'b0111100;
  localparam logic [6:0] C_REDIR = 7'b0000011;
  localparam logic [6:0] C_FLUSH = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_s3;
  logic        load_s2;
  logic [4:0]  rd_s2;
  logic [4:0]  rs1_s1;
  logic [4:0]  rs2_s1;
  logic        rs1_used_s1;
  logic        rs2_used_s1;
  logic        mem_busy;
  logic        pc_rst;
  logic        stall_pc;
  logic        stall_s1;
  logic        stall_s2;
  logic        stall_s3;
  logic        bubble_s2;
  logic        flush_s1;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          vec   = 0;
  logic [31:0] exp_sc = '0;
  logic [31:0] exp_fc = '0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES (2),
    .IMEM_LAT    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect_s3 (redirect_s3),
    .load_s2     (load_s2),
    .rd_s2       (rd_s2),
    .rs1_s1      (rs1_s1),
    .rs2_s1      (rs2_s1),
    .rs1_used_s1 (rs1_used_s1),
    .rs2_used_s1 (rs2_used_s1),
    .mem_busy    (mem_busy),
    .pc_rst      (pc_rst),
    .stall_pc    (stall_pc),
    .stall_s1    (stall_s1),
    .stall_s2    (stall_s2),
    .stall_s3    (stall_s3),
    .bubble_s2   (bubble_s2),
    .flush_s1    (flush_s1),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  // Drive one cycle of inputs and queue the expected response.
  task automatic step(
    input logic       r,
    input logic       redir,
    input logic       ld,
    input logic [4:0] rd,
    input logic [4:0] a1,
    input logic       u1,
    input logic [4:0] a2,
    input logic       u2,
    input logic       busy,
    input logic [6:0] ctl
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    redirect_s3 = redir;
    load_s2     = ld;
    rd_s2       = rd;
    rs1_s1      = a1;
    rs1_used_s1 = u1;
    rs2_s1      = a2;
    rs2_used_s1 = u2;
    mem_busy    = busy;
    if (r) begin
      exp_sc = '0;
      exp_fc = '0;
    end
    e.ctl = ctl;
    e.sc  = exp_sc;
    e.fc  = exp_fc;
    e.id  = vec;
    sb.push_back(e);
    vec++;
`ifdef HAZARD_PERF_CNT_EN
    if (!r && ctl[5])
      exp_sc = exp_sc + 1;
    if (!r && ctl == C_REDIR)
      exp_fc = exp_fc + 1;
`endif
  endtask

  task automatic idle(input logic [6:0] ctl);
    step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, ctl);
  endtask

  task automatic haz(input logic redir, input logic busy,
                     input logic [6:0] ctl);
    step(0, redir, 1, 5'd5, 5'd3, 1, 5'd5, 1, busy, ctl);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_rst, stall_pc, stall_s1, stall_s2,
             stall_s3, bubble_s2, flush_s1};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL ctl v%0d: got %b want %b", e.id, act, e.ctl);
      end
      total++;
      if (stall_cnt !== e.sc) begin
        bad++;
        $display("FAIL stall_cnt v%0d: got %0d want %0d",
                 e.id, stall_cnt, e.sc);
      end
      total++;
      if (flush_cnt !== e.fc) begin
        bad++;
        $display("FAIL flush_cnt v%0d: got %0d want %0d",
                 e.id, flush_cnt, e.fc);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    redirect_s3 = 1'b0;
    load_s2     = 1'b0;
    rd_s2       = '0;
    rs1_s1      = '0;
    rs2_s1      = '0;
    rs1_used_s1 = 1'b0;
    rs2_used_s1 = 1'b0;
    mem_busy    = 1'b0;

    // reset and boot
    step(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, C_BOOT);
    idle(C_BOOT);
    idle(C_BOOT);
    idle(C_NONE);
    idle(C_NONE);

    // load-use on rs2, then rs1, then unused source
    step(0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, C_HAZ);
    idle(C_NONE);
    step(0, 0, 1, 5'd7, 5'd7, 1, 5'd1, 1, 0, C_HAZ);
    idle(C_NONE);
    step(0, 0, 1, 5'd7, 5'd7, 0, 5'd1, 1, 0, C_NONE);
    // x0 destination never stalls
    step(0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, C_NONE);
    // hazard seen again in LDSTALL
    haz(0, 0, C_HAZ);
    haz(0, 0, C_HAZ);
    idle(C_NONE);

    // plain redirect
    step(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, C_REDIR);
    idle(C_FLUSH);
    idle(C_NONE);

    // busy three cycles with a redirect on the first
    step(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, C_BUSY);
    step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, C_BUSY);
    step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, C_BUSY);
    idle(C_REDIR);
    idle(C_FLUSH);
    idle(C_NONE);

    // redirect beats hazard; hazard ignored during FLUSH
    haz(1, 0, C_REDIR);
    haz(0, 0, C_FLUSH);
    idle(C_NONE);

    // redirect arriving in FLUSH restarts the flush
    step(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, C_REDIR);
    step(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, C_REDIR);
    idle(C_FLUSH);
    idle(C_NONE);

    // busy while in FLUSH holds the state
    step(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, C_REDIR);
    step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, C_BUSY);
    idle(C_FLUSH);
    idle(C_NONE);

    // busy outranks hazard
    haz(0, 1, C_BUSY);
    idle(C_NONE);

    // reset during a load stall
    haz(0, 0, C_HAZ);
    step(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, C_BOOT);
    idle(C_BOOT);
    idle(C_BOOT);
    idle(C_NONE);

    // reset clears a pending redirect
    step(0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, C_BUSY);
    step(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, C_BOOT);
    idle(C_BOOT);
    idle(C_BOOT);
    idle(C_NONE);
    idle(C_NONE);

    repeat (4) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
